// File: rtl/serial_link.sv
// serial_link: UART-style serial transmitter and receiver for a processor PIO.
// Frame: start 0, 8 data bits LSB first, optional even parity, stop 1.
// Define SERIAL_LINK_PARITY_EN to add the even-parity bit (11-bit frames);
// without it the frame is 10 bits and the PARITY states are never entered.
module serial_link #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] data_out,
   input  logic       load,
   input  logic       trans_en,
   input  logic       char_read,
   output logic [7:0] data_in,
   output logic       char_recv,
   output logic       char_sent,
   output logic       rx_error,
   output logic       tx,
   input  logic       rx
);

`ifdef SERIAL_LINK_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   // ---------------- transmitter state ----------------
   state_t           tx_state_q, tx_state_d;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]       tx_idx_q, tx_idx_d;
   logic [7:0]       tx_shift_q, tx_shift_d;
   logic             tx_par_q, tx_par_d;
   logic             tx_q, tx_d;
   logic [7:0]       hold_q, hold_d;
   logic             hold_valid_q, hold_valid_d;
   logic             char_sent_q, char_sent_d;
   logic             tx_last;

   // ---------------- receiver state ----------------
   logic             rx_meta_q, rx_sync_q;
   logic             char_read_q;
   state_t           rx_state_q, rx_state_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]       rx_idx_q, rx_idx_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic             rx_par_err_q, rx_par_err_d;
   logic             rx_wait_q, rx_wait_d;
   logic [7:0]       data_in_q, data_in_d;
   logic             char_recv_q, char_recv_d;
   logic             rx_error_q, rx_error_d;
   logic             rx_last;
   logic             read_rise;

   assign tx        = tx_q;
   assign char_sent = char_sent_q;
   assign data_in   = data_in_q;
   assign char_recv = char_recv_q;
   assign rx_error  = rx_error_q;

   assign tx_last   = (tx_cnt_q == CNT_LAST);
   assign rx_last   = (rx_cnt_q == CNT_LAST);
   assign read_rise = char_read & ~char_read_q;

   // TX next state: walk the frame bit by bit, the line level is registered
   always_comb begin
      tx_state_d   = tx_state_q;
      tx_cnt_d     = tx_cnt_q;
      tx_idx_d     = tx_idx_q;
      tx_shift_d   = tx_shift_q;
      tx_par_d     = tx_par_q;
      tx_d         = tx_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      char_sent_d  = char_sent_q;

      if (tx_state_q != ST_IDLE) begin
         tx_cnt_d = tx_last ? '0 : tx_cnt_q + 1'b1;
      end

      case (tx_state_q)
         ST_IDLE: begin
            tx_d     = 1'b1;
            tx_cnt_d = '0;
            if (trans_en && hold_valid_q) begin
               tx_state_d   = ST_START;
               tx_shift_d   = hold_q;
               tx_par_d     = ^hold_q;
               hold_valid_d = 1'b0;
               tx_d         = 1'b0;
            end
         end
         ST_START: begin
            if (tx_last) begin
               tx_state_d = ST_DATA;
               tx_idx_d   = 3'd0;
               tx_d       = tx_shift_q[0];
            end
         end
         ST_DATA: begin
            if (tx_last) begin
               if (tx_idx_q == 3'd7) begin
                  if (PARITY_EN) begin
                     tx_state_d = ST_PARITY;
                     tx_d       = tx_par_q;
                  end else begin
                     tx_state_d = ST_STOP;
                     tx_d       = 1'b1;
                  end
               end else begin
                  tx_idx_d   = tx_idx_q + 3'd1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  tx_d       = tx_shift_q[1];
               end
            end
         end
         ST_PARITY: begin
            if (tx_last) begin
               tx_state_d = ST_STOP;
               tx_d       = 1'b1;
            end
         end
         ST_STOP: begin
            if (tx_last) begin
               tx_state_d = ST_IDLE;
               tx_d       = 1'b1;
               if (!hold_valid_q) begin
                  char_sent_d = 1'b1;
               end
            end
         end
         default: begin
            tx_state_d = ST_IDLE;
            tx_d       = 1'b1;
         end
      endcase

      // A load only touches the holding register; bits in flight are untouched
      if (load) begin
         hold_d       = data_out;
         hold_valid_d = 1'b1;
         char_sent_d  = 1'b0;
      end
   end

   // TX registers; reset parks the line high and aborts any frame
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_state_q   <= ST_IDLE;
         tx_cnt_q     <= '0;
         tx_idx_q     <= 3'd0;
         tx_shift_q   <= 8'h00;
         tx_par_q     <= 1'b0;
         tx_q         <= 1'b1;
         hold_q       <= 8'h00;
         hold_valid_q <= 1'b0;
         char_sent_q  <= 1'b1;
      end else begin
         tx_state_q   <= tx_state_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_idx_q     <= tx_idx_d;
         tx_shift_q   <= tx_shift_d;
         tx_par_q     <= tx_par_d;
         tx_q         <= tx_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         char_sent_q  <= char_sent_d;
      end
   end

   // Two-flop synchroniser for rx (idle high) and edge-detect history for char_read
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta_q   <= 1'b1;
         rx_sync_q   <= 1'b1;
         char_read_q <= 1'b0;
      end else begin
         rx_meta_q   <= rx;
         rx_sync_q   <= rx_meta_q;
         char_read_q <= char_read;
      end
   end

   // RX next state: mid-bit sampling, glitch rejection and status flag updates
   always_comb begin
      rx_state_d   = rx_state_q;
      rx_cnt_d     = rx_cnt_q;
      rx_idx_d     = rx_idx_q;
      rx_shift_d   = rx_shift_q;
      rx_par_err_d = rx_par_err_q;
      rx_wait_d    = rx_wait_q;
      data_in_d    = data_in_q;
      char_recv_d  = char_recv_q;
      rx_error_d   = rx_error_q;

      // Acknowledge first so a character completing on the same edge wins
      if (read_rise) begin
         char_recv_d = 1'b0;
         rx_error_d  = 1'b0;
      end

      case (rx_state_q)
         ST_IDLE: begin
            rx_cnt_d = '0;
            if (rx_wait_q) begin
               if (rx_sync_q) begin
                  rx_wait_d = 1'b0;
               end
            end else if (!rx_sync_q) begin
               rx_state_d = ST_START;
            end
         end
         ST_START: begin
            if (rx_cnt_q == CNT_HALF) begin
               rx_cnt_d = '0;
               if (rx_sync_q) begin
                  rx_state_d = ST_IDLE;
               end else begin
                  rx_state_d   = ST_DATA;
                  rx_idx_d     = 3'd0;
                  rx_par_err_d = 1'b0;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            rx_cnt_d = rx_last ? '0 : rx_cnt_q + 1'b1;
            if (rx_last) begin
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               if (rx_idx_q == 3'd7) begin
                  rx_state_d = PARITY_EN ? ST_PARITY : ST_STOP;
               end else begin
                  rx_idx_d = rx_idx_q + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            rx_cnt_d = rx_last ? '0 : rx_cnt_q + 1'b1;
            if (rx_last) begin
               rx_par_err_d = rx_sync_q ^ (^rx_shift_q);
               rx_state_d   = ST_STOP;
            end
         end
         ST_STOP: begin
            rx_cnt_d = rx_last ? '0 : rx_cnt_q + 1'b1;
            if (rx_last) begin
               rx_state_d = ST_IDLE;
               if (rx_sync_q && !rx_par_err_q) begin
                  data_in_d   = rx_shift_q;
                  char_recv_d = 1'b1;
               end else begin
                  rx_error_d = 1'b1;
                  if (!rx_sync_q) begin
                     rx_wait_d = 1'b1;
                  end
               end
            end
         end
         default: begin
            rx_state_d = ST_IDLE;
         end
      endcase
   end

   // RX registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_state_q   <= ST_IDLE;
         rx_cnt_q     <= '0;
         rx_idx_q     <= 3'd0;
         rx_shift_q   <= 8'h00;
         rx_par_err_q <= 1'b0;
         rx_wait_q    <= 1'b0;
         data_in_q    <= 8'h00;
         char_recv_q  <= 1'b0;
         rx_error_q   <= 1'b0;
      end else begin
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_idx_q     <= rx_idx_d;
         rx_shift_q   <= rx_shift_d;
         rx_par_err_q <= rx_par_err_d;
         rx_wait_q    <= rx_wait_d;
         data_in_q    <= data_in_d;
         char_recv_q  <= char_recv_d;
         rx_error_q   <= rx_error_d;
      end
   end

endmodule
